pipe_stall_ctrl: RTL and testbench

//  Central pipeline hazard controller. Merges per-stage stall requests and a multi-cycle-op timer into one hold vector,
//  and arbitrates branch/exception flushes with a held-request/ack handshake.

---
 rtl/pipe_stall_ctrl_if.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall/flush controller.
// The master side is the pipeline (requesters); the slave side is pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(
    parameter int STALL_W = 8,
    parameter int TMR_W   = 6,
    parameter int CNT_W   = 32,
    parameter int LVL_W   = $clog2(STALL_W)
);
    logic [STALL_W-1:0] stallreq;
    logic               mc_start;
    logic [TMR_W-1:0]   mc_len;
    logic               mc_done;
    logic               flush_req;
    logic [LVL_W-1:0]   flush_lvl;
    logic               flush_ack;
    logic [STALL_W-1:0] stall;
    logic [STALL_W-1:0] flush;
    logic               stall_timeout;
    logic [CNT_W-1:0]   stall_cycles;
    logic [CNT_W-1:0]   flush_count;

    modport master (
        output stallreq, mc_start, mc_len, flush_req, flush_lvl,
        input  mc_done, flush_ack, stall, flush, stall_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  stallreq, mc_start, mc_len, flush_req, flush_lvl,
        output mc_done, flush_ack, stall, flush, stall_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline hazard controller: merges stage stall requests with a multi-cycle-op
// timer into one hold vector, arbitrates flushes, and keeps a watchdog and perf counters.
module pipe_stall_ctrl #(
    parameter int STALL_W    = 8,
    parameter int MC_STAGE   = 4,
    parameter int TMR_W      = 6,
    parameter int WDOG_LIMIT = 1023,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stall_ctrl_if.slave bus
);

    localparam int LVL_W = $clog2(STALL_W);
    localparam int WD_W  = $clog2(WDOG_LIMIT + 1);
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(STALL_W - 2);
    localparam logic [LVL_W-1:0] MC_LVL  = LVL_W'(MC_STAGE);

    typedef enum logic {
        IDLE,
        MCYC
    } mc_state_t;

    mc_state_t          state, state_nxt;
    logic [TMR_W-1:0]   mc_cnt, mc_cnt_nxt;
    logic [TMR_W-1:0]   mc_l;
    logic               mc_active_raw;
    logic               mc_done_c;
    logic [STALL_W-1:0] req_mask;
    logic [STALL_W-1:0] mc_mask;
    logic [STALL_W-1:0] stall_raw;
    logic [STALL_W-1:0] chk_raw;
    logic [STALL_W-1:0] flush_mask;
    logic [LVL_W-1:0]   f_lvl;
    logic               killed;
    logic               accept;
    logic               kill_now;
    logic [WD_W-1:0]    wd_cnt;
    logic               timeout_q;
    logic [CNT_W-1:0]   stall_cycles_q;
    logic [CNT_W-1:0]   flush_count_q;

    // Ones over bits [k:0]; a shift past the top bit yields an all-ones mask.
    function automatic logic [STALL_W-1:0] ones_upto(input logic [LVL_W-1:0] k);
        return ~({STALL_W{1'b1}} << (32'(k) + 32'd1));
    endfunction

    // The highest requesting stage wins; it holds itself and everything upstream.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < STALL_W; i++) begin
            if (bus.stallreq[i]) begin
                req_mask = ones_upto(LVL_W'(i));
            end
        end
    end

    assign mc_l          = (bus.mc_len == '0) ? TMR_W'(1) : bus.mc_len;
    assign mc_active_raw = (state == MCYC) || ((state == IDLE) && bus.mc_start);
    assign mc_mask       = mc_active_raw ? ones_upto(MC_LVL) : '0;
    assign stall_raw     = req_mask | mc_mask;

    // A flush that reaches the MC stage kills the op, so its hold cannot block the flush.
    assign f_lvl      = (bus.flush_lvl > MAX_LVL) ? MAX_LVL : bus.flush_lvl;
    assign killed     = (f_lvl >= MC_LVL);
    assign flush_mask = ones_upto(f_lvl);
    assign chk_raw    = req_mask | (killed ? '0 : mc_mask);
    assign accept     = bus.flush_req && ((chk_raw & ~flush_mask) == '0);
    assign kill_now   = accept && killed;

    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        mc_done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mc_start && !kill_now) begin
                    if (mc_l == TMR_W'(1)) begin
                        mc_done_c = 1'b1;
                    end else begin
                        state_nxt  = MCYC;
                        mc_cnt_nxt = mc_l - TMR_W'(1);
                    end
                end
            end
            MCYC: begin
                if (kill_now) begin
                    state_nxt  = IDLE;
                    mc_cnt_nxt = '0;
                end else if (mc_cnt == TMR_W'(1)) begin
                    mc_done_c  = 1'b1;
                    state_nxt  = IDLE;
                    mc_cnt_nxt = '0;
                end else begin
                    mc_cnt_nxt = mc_cnt - TMR_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                mc_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Watchdog counts consecutive PC-hold cycles; the timeout flag stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (bus.stall[0]) begin
            if (wd_cnt != WD_W'(WDOG_LIMIT)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_cnt >= WD_W'(WDOG_LIMIT - 1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (bus.stall[0] && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (bus.flush_ack && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall         = (rst_n && !accept) ? stall_raw : '0;
    assign bus.flush         = (rst_n && accept) ? flush_mask : '0;
    assign bus.flush_ack     = rst_n && accept;
    assign bus.mc_done       = rst_n && mc_done_c;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (STALL_W=8, MC_STAGE=4, WDOG_LIMIT=16).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_stall_ctrl_if #(.STALL_W(8), .TMR_W(6), .CNT_W(32)) bus ();

    pipe_stall_ctrl #(
        .STALL_W   (8),
        .MC_STAGE  (4),
        .TMR_W     (6),
        .WDOG_LIMIT(16),
        .CNT_W     (32)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] sr, input logic ms, input logic [5:0] ml,
                                 input logic fr, input logic [2:0] fl);
        @(negedge clk);
        bus.stallreq  = sr;
        bus.mc_start  = ms;
        bus.mc_len    = ml;
        bus.flush_req = fr;
        bus.flush_lvl = fl;
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.stallreq  = '0;
        bus.mc_start  = 1'b0;
        bus.mc_len    = '0;
        bus.flush_req = 1'b0;
        bus.flush_lvl = '0;
        #2;
        checkOutput("rst_stall", 32'(bus.stall), 32'h0);
        checkOutput("rst_flush", 32'(bus.flush), 32'h0);
        checkOutput("rst_ack", 32'(bus.flush_ack), 32'h0);
        checkOutput("rst_timeout", 32'(bus.stall_timeout), 32'h0);
        checkOutput("rst_stall_cycles", bus.stall_cycles, 32'h0);
        checkOutput("rst_flush_count", bus.flush_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall merge
        applyStimulus(8'h08, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("merge_08", 32'(bus.stall), 32'h0F);
        checkOutput("merge_08_flush", 32'(bus.flush), 32'h0);
        applyStimulus(8'h28, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("merge_28", 32'(bus.stall), 32'h3F);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("merge_00", 32'(bus.stall), 32'h0);
        checkOutput("cycles_a", bus.stall_cycles, 32'd2);

        // Multi-cycle op, length 3 then length 0
        applyStimulus(8'h00, 1'b1, 6'd3, 1'b0, 3'd0);
        checkOutput("mc3_t0_stall", 32'(bus.stall), 32'h1F);
        checkOutput("mc3_t0_done", 32'(bus.mc_done), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("mc3_t1_stall", 32'(bus.stall), 32'h1F);
        checkOutput("mc3_t1_done", 32'(bus.mc_done), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("mc3_t2_stall", 32'(bus.stall), 32'h1F);
        checkOutput("mc3_t2_done", 32'(bus.mc_done), 32'h1);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("mc3_t3_stall", 32'(bus.stall), 32'h0);
        checkOutput("mc3_t3_done", 32'(bus.mc_done), 32'h0);
        checkOutput("cycles_b", bus.stall_cycles, 32'd5);
        applyStimulus(8'h00, 1'b1, 6'd0, 1'b0, 3'd0);
        checkOutput("mc0_stall", 32'(bus.stall), 32'h1F);
        checkOutput("mc0_done", 32'(bus.mc_done), 32'h1);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("mc0_after", 32'(bus.stall), 32'h0);
        checkOutput("cycles_c", bus.stall_cycles, 32'd6);

        // Flush blocked by a downstream stall, then accepted
        applyStimulus(8'h20, 1'b0, 6'd0, 1'b1, 3'd3);
        checkOutput("fl3_blk_ack", 32'(bus.flush_ack), 32'h0);
        checkOutput("fl3_blk_stall", 32'(bus.stall), 32'h3F);
        checkOutput("fl3_blk_flush", 32'(bus.flush), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b1, 3'd3);
        checkOutput("fl3_ack", 32'(bus.flush_ack), 32'h1);
        checkOutput("fl3_flush", 32'(bus.flush), 32'h0F);
        checkOutput("fl3_stall", 32'(bus.stall), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("fl3_count", bus.flush_count, 32'd1);
        checkOutput("fl3_ack_drop", 32'(bus.flush_ack), 32'h0);
        checkOutput("cycles_d", bus.stall_cycles, 32'd7);

        // Flush at F=4 kills an in-flight MC op (mc_cnt=5)
        applyStimulus(8'h00, 1'b1, 6'd7, 1'b0, 3'd0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("kill_pre_stall", 32'(bus.stall), 32'h1F);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b1, 3'd4);
        checkOutput("kill_ack", 32'(bus.flush_ack), 32'h1);
        checkOutput("kill_flush", 32'(bus.flush), 32'h1F);
        checkOutput("kill_stall", 32'(bus.stall), 32'h0);
        checkOutput("kill_done", 32'(bus.mc_done), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("kill_post_stall", 32'(bus.stall), 32'h0);
        checkOutput("kill_post_done", 32'(bus.mc_done), 32'h0);
        checkOutput("kill_count", bus.flush_count, 32'd2);
        checkOutput("cycles_e", bus.stall_cycles, 32'd9);

        // Flush at F=2 must wait for the MC op (length 4) to complete
        applyStimulus(8'h00, 1'b1, 6'd4, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b0, 6'd0, 1'b1, 3'd2);
            checkOutput("wait_ack", 32'(bus.flush_ack), 32'h0);
            checkOutput("wait_stall", 32'(bus.stall), 32'h1F);
            checkOutput("wait_done", 32'(bus.mc_done), (i == 2) ? 32'h1 : 32'h0);
        end
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b1, 3'd2);
        checkOutput("wait_ack_late", 32'(bus.flush_ack), 32'h1);
        checkOutput("wait_flush_late", 32'(bus.flush), 32'h07);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("wait_count", bus.flush_count, 32'd3);
        checkOutput("cycles_f", bus.stall_cycles, 32'd13);

        // flush_lvl=7 clamps to F=6
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b1, 3'd7);
        checkOutput("clamp_flush", 32'(bus.flush), 32'h7F);
        checkOutput("clamp_ack", 32'(bus.flush_ack), 32'h1);
        applyStimulus(8'h80, 1'b0, 6'd0, 1'b1, 3'd7);
        checkOutput("clamp_blk_ack", 32'(bus.flush_ack), 32'h0);
        checkOutput("clamp_blk_stall", 32'(bus.stall), 32'hFF);

        // mc_start together with a killing flush is discarded
        applyStimulus(8'h00, 1'b1, 6'd3, 1'b1, 3'd5);
        checkOutput("disc_flush", 32'(bus.flush), 32'h3F);
        checkOutput("disc_done", 32'(bus.mc_done), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("disc_stall", 32'(bus.stall), 32'h0);
        checkOutput("disc_count", bus.flush_count, 32'd5);
        checkOutput("cycles_g", bus.stall_cycles, 32'd14);

        // Watchdog trips after the 16th consecutive stalled cycle and stays set
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h08, 1'b0, 6'd0, 1'b0, 3'd0);
            if (i == 15) checkOutput("wdog_before", 32'(bus.stall_timeout), 32'h0);
            if (i == 16) checkOutput("wdog_trip", 32'(bus.stall_timeout), 32'h1);
        end
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("wdog_sticky", 32'(bus.stall_timeout), 32'h1);
        checkOutput("cycles_h", bus.stall_cycles, 32'd34);

        // Asynchronous reset in the middle of an MC op
        applyStimulus(8'h00, 1'b1, 6'd10, 1'b0, 3'd0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("arst_pre_stall", 32'(bus.stall), 32'h1F);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_stall", 32'(bus.stall), 32'h0);
        checkOutput("arst_timeout", 32'(bus.stall_timeout), 32'h0);
        checkOutput("arst_cycles", bus.stall_cycles, 32'h0);
        checkOutput("arst_count", bus.flush_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00, 1'b1, 6'd2, 1'b0, 3'd0);
        checkOutput("post_mc2_t0", 32'(bus.stall), 32'h1F);
        checkOutput("post_mc2_d0", 32'(bus.mc_done), 32'h0);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("post_mc2_t1", 32'(bus.stall), 32'h1F);
        checkOutput("post_mc2_d1", 32'(bus.mc_done), 32'h1);
        applyStimulus(8'h00, 1'b0, 6'd0, 1'b0, 3'd0);
        checkOutput("post_mc2_t2", 32'(bus.stall), 32'h0);
        checkOutput("post_cycles", bus.stall_cycles, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
